drive_mode_arbiter: RTL and testbench
=====================================

DRIVE_MODE_ARBITER -- requirements
Module: drive_mode_arbiter

Interface
REQ-001 Parameter LONG_PRESS_CYC, default 100_000_000, SHALL set the power-button hold time in clk cycles needed to power on (1 s at 100 MHz).
REQ-002 Parameter SWITCH_GAP, default 2, SHALL set the number of zero-output cycles inserted on every mode entry.
REQ-003 clk  input  1  system clock, 100 MHz, P17.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 power_btn  input  1  power button, already synchronised and debounced; 1 = pressed.
REQ-006 mode_sel  input  2  mode switches: 00 manual, 01 semi-auto, 10 auto, 11 invalid.
REQ-007 manual_answer  input  4  manual-mode command {left,right,back,forward}.
REQ-008 manual_power_now  input  1  manual-mode shutdown flag; 1 = manual block has entered power_off.
REQ-009 semi_answer  input  4  semi-auto command, same bit order.
REQ-010 auto_answer  input  4  auto command, same bit order.
REQ-011 manual_rst_n  output  1  active-low reset to the manual block.
REQ-012 manual_power_input  output  1  hold to the manual block; 1 forces it to power_off.
REQ-013 semi_en  output  1  enable for the semi-auto block.
REQ-014 auto_en  output  1  enable for the auto block.
REQ-015 drive_cmd  output  4  registered motor command {left,right,back,forward}.
REQ-016 power_on  output  1  car powered.
REQ-017 active_mode  output  2  mode currently granted.
REQ-018 fsm_state  output  3  current state, for debug LEDs.

Function
REQ-019 States SHALL be OFF, ARM, WAIT_REL, SWITCH and RUN.
REQ-020 OFF: power_btn=1 SHALL go to ARM with the press counter at 0.
REQ-021 ARM: power_btn=0 SHALL go back to OFF; power_btn held with counter = LONG_PRESS_CYC-1 SHALL go to WAIT_REL and set power_on=1.
REQ-022 On the ARM->WAIT_REL transition, target mode SHALL latch mode_sel, with 11 mapped to manual.
REQ-023 WAIT_REL: power_btn=0 SHALL go to SWITCH; while the button is held, no power-off SHALL be recognised.
REQ-024 SWITCH: the block SHALL stay exactly SWITCH_GAP cycles, then enter RUN with active_mode = target.
REQ-025 SWITCH: power_btn=1 SHALL go to OFF.
REQ-026 RUN: power_btn=1 SHALL go to OFF on the next edge.
REQ-027 RUN: otherwise, mode_sel valid and != active_mode SHALL go to SWITCH with target = mode_sel; mode_sel=11 SHALL be ignored.
REQ-028 RUN: otherwise, active_mode=manual with manual_power_now=1 SHALL go to OFF.
REQ-029 Priority SHALL be power_btn > mode change > manual_power_now.
REQ-030 drive_cmd SHALL be registered, equal to the granted mode's answer one cycle after that answer, and SHALL be 0 in every state except RUN.
REQ-031 manual_rst_n and ~manual_power_input SHALL be 1 only in RUN with active_mode=manual, so each manual entry restarts the manual block from unstarting.
REQ-032 semi_en SHALL be 1 only in RUN with active_mode=semi-auto; auto_en SHALL be 1 only in RUN with active_mode=auto.
REQ-033 power_on SHALL be 1 in WAIT_REL, SWITCH and RUN, and 0 in OFF and ARM.
REQ-034 The press counter SHALL saturate at its terminal value and SHALL be cleared on ARM exit.

Reset
REQ-035 On rst=0, state SHALL be OFF, counters 0, active_mode=00 and target=00.
REQ-036 On rst=0, drive_cmd=0, power_on=0, manual_rst_n=0, manual_power_input=1, semi_en=0 and auto_en=0, immediately and independently of clk.
REQ-037 Reset asserted mid-ARM or mid-SWITCH SHALL abandon the count; no partial power-on SHALL survive.

Structure
REQ-038 State encodings, mode codes (MODE_MANUAL, MODE_SEMI, MODE_AUTO) and the command bit order SHALL live in shared package drive_pkg.
REQ-039 The press and gap timing SHALL use one sub-module, hold_timer (load, enable, terminal flag), instantiated twice.

Verification (LONG_PRESS_CYC=8, SWITCH_GAP=2)
REQ-040 Hold power_btn 5 cycles, then release: SHALL return to OFF with power_on staying 0.
REQ-041 Hold power_btn 8 cycles with mode_sel=01, release: SHALL give power_on=1, two zero cycles, then RUN, semi_en=1, and drive_cmd following semi_answer (0001 -> 0001) with 1-cycle lag.
REQ-042 In RUN manual, change mode_sel to 10: SHALL give drive_cmd=0 for 2 cycles, manual_rst_n=0, and auto_en=1 with active_mode=10 afterwards.
REQ-043 In RUN manual, pulse manual_power_now=1: SHALL go to OFF next cycle with drive_cmd=0 and manual_power_input=1.
REQ-044 In RUN auto, assert power_btn and change mode_sel in the same cycle: SHALL go to OFF with no SWITCH entered.
REQ-045 Assert rst=0 at count 6 in ARM: outputs SHALL reach their reset values asynchronously; a subsequent 7-cycle press SHALL NOT power on.

Source files
------------

// File: rtl/drive_pkg.sv
// ============================================================================
//  Module   : drive_pkg
//  Purpose  : Shared definitions for the drive-mode arbiter: FSM state
//             encodings, mode codes, motor-command bit positions and a helper
//             that folds the invalid mode code onto manual.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package drive_pkg;

    // FSM state encodings (3 bits, also shown on the debug LEDs)
    localparam logic [2:0] c_ST_OFF      = 3'd0;
    localparam logic [2:0] c_ST_ARM      = 3'd1;
    localparam logic [2:0] c_ST_WAIT_REL = 3'd2;
    localparam logic [2:0] c_ST_SWITCH   = 3'd3;
    localparam logic [2:0] c_ST_RUN      = 3'd4;

    // Mode switch codes
    localparam logic [1:0] MODE_MANUAL  = 2'b00;
    localparam logic [1:0] MODE_SEMI    = 2'b01;
    localparam logic [1:0] MODE_AUTO    = 2'b10;
    localparam logic [1:0] MODE_INVALID = 2'b11;

    // Motor command bit order: {left, right, back, forward}
    localparam int c_CMD_W       = 4;
    localparam int c_CMD_FORWARD = 0;
    localparam int c_CMD_BACK    = 1;
    localparam int c_CMD_RIGHT   = 2;
    localparam int c_CMD_LEFT    = 3;

    // The invalid switch setting powers up into manual mode.
    function automatic logic [1:0] sanitize_mode(input logic [1:0] mode);
        return (mode == MODE_INVALID) ? MODE_MANUAL : mode;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hold_timer.sv
// ============================================================================
//  Module   : hold_timer
//  Purpose  : Saturating up-counter with synchronous clear. done is high while
//             the count equals TERMINAL; the count holds there until loaded.
//  Ports    : clk     - clock
//             rst     - asynchronous active-low reset
//             load    - clear the count to 0 (has priority over enable)
//             enable  - advance the count by one
//             done    - count has reached TERMINAL
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_timer #(
    parameter int TERMINAL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic done
);

    localparam int             c_W    = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1);
    localparam logic [c_W-1:0] c_TERM = c_W'(TERMINAL);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= '0;
        end else if (enable && !done) begin
            r_count <= r_count + c_W'(1);
        end
    end

    assign done = (r_count == c_TERM);

endmodule

`default_nettype wire

// File: rtl/drive_mode_arbiter.sv
// ============================================================================
//  Module   : drive_mode_arbiter
//  Purpose  : Power sequencing and drive-mode arbitration for the car. A long
//             press powers on, the mode switches pick which controller drives
//             the motors, and every mode entry inserts SWITCH_GAP idle cycles.
//  Ports    : clk                - system clock (100 MHz)
//             rst                - asynchronous active-low reset
//             power_btn          - debounced power button, 1 = pressed
//             mode_sel           - 00 manual, 01 semi-auto, 10 auto, 11 invalid
//             manual_answer      - manual controller command
//             manual_power_now   - manual controller has powered itself off
//             semi_answer        - semi-auto controller command
//             auto_answer        - auto controller command
//             manual_rst_n       - active-low reset to manual controller
//             manual_power_input - 1 holds manual controller in power_off
//             semi_en / auto_en  - enables for the semi-auto / auto controllers
//             drive_cmd          - registered motor command {L,R,B,F}
//             power_on           - car powered
//             active_mode        - mode currently granted
//             fsm_state          - FSM state for debug LEDs
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module drive_mode_arbiter
    import drive_pkg::*;
#(
    parameter int LONG_PRESS_CYC = 100_000_000,
    parameter int SWITCH_GAP     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               power_btn,
    input  logic [1:0]         mode_sel,
    input  logic [c_CMD_W-1:0] manual_answer,
    input  logic               manual_power_now,
    input  logic [c_CMD_W-1:0] semi_answer,
    input  logic [c_CMD_W-1:0] auto_answer,
    output logic               manual_rst_n,
    output logic               manual_power_input,
    output logic               semi_en,
    output logic               auto_en,
    output logic [c_CMD_W-1:0] drive_cmd,
    output logic               power_on,
    output logic [1:0]         active_mode,
    output logic [2:0]         fsm_state
);

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic [1:0]         r_active_mode;
    logic [1:0]         r_target_mode;
    logic [1:0]         w_next_mode;
    logic [c_CMD_W-1:0] r_drive_cmd;
    logic [c_CMD_W-1:0] w_cmd_sel;
    logic               w_press_done;
    logic               w_gap_done;
    logic               w_mode_change;
    logic               w_run_manual;

    // ---------------------------------------------------------------- timers
    // Both counters sit cleared outside their own state, so each entry into
    // ARM or SWITCH starts counting from zero.
    hold_timer #(.TERMINAL(LONG_PRESS_CYC - 1)) u_press_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (r_state != c_ST_ARM),
        .enable ((r_state == c_ST_ARM) && power_btn),
        .done   (w_press_done)
    );

    hold_timer #(.TERMINAL(SWITCH_GAP - 1)) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (r_state != c_ST_SWITCH),
        .enable (r_state == c_ST_SWITCH),
        .done   (w_gap_done)
    );

    // A request to a different, valid mode while running.
    assign w_mode_change = (mode_sel != MODE_INVALID) && (mode_sel != r_active_mode);

    // ------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_OFF;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------ next state
    // In RUN the button outranks a mode change, which outranks the manual
    // controller's own shutdown request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_OFF: begin
                if (power_btn) w_next_state = c_ST_ARM;
            end
            c_ST_ARM: begin
                if (!power_btn)        w_next_state = c_ST_OFF;
                else if (w_press_done) w_next_state = c_ST_WAIT_REL;
            end
            c_ST_WAIT_REL: begin
                // The power-on press itself must not be read as power-off.
                if (!power_btn) w_next_state = c_ST_SWITCH;
            end
            c_ST_SWITCH: begin
                if (power_btn)       w_next_state = c_ST_OFF;
                else if (w_gap_done) w_next_state = c_ST_RUN;
            end
            c_ST_RUN: begin
                if (power_btn)
                    w_next_state = c_ST_OFF;
                else if (w_mode_change)
                    w_next_state = c_ST_SWITCH;
                else if ((r_active_mode == MODE_MANUAL) && manual_power_now)
                    w_next_state = c_ST_OFF;
            end
            default: w_next_state = c_ST_OFF;
        endcase
    end

    // ---------------------------------------------------------- mode tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active_mode <= MODE_MANUAL;
            r_target_mode <= MODE_MANUAL;
        end else begin
            if ((r_state == c_ST_ARM) && (w_next_state == c_ST_WAIT_REL))
                r_target_mode <= sanitize_mode(mode_sel);
            else if ((r_state == c_ST_RUN) && (w_next_state == c_ST_SWITCH))
                r_target_mode <= mode_sel;

            if ((r_state == c_ST_SWITCH) && (w_next_state == c_ST_RUN))
                r_active_mode <= r_target_mode;
        end
    end

    // --------------------------------------------------------- drive command
    // Select against the mode that will be granted after this edge so the
    // registered command lines up with the state register.
    assign w_next_mode = (r_state == c_ST_SWITCH) ? r_target_mode : r_active_mode;

    always_comb begin
        w_cmd_sel = '0;
        case (w_next_mode)
            MODE_MANUAL: w_cmd_sel = manual_answer;
            MODE_SEMI:   w_cmd_sel = semi_answer;
            MODE_AUTO:   w_cmd_sel = auto_answer;
            default:     w_cmd_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drive_cmd <= '0;
        end else begin
            r_drive_cmd <= (w_next_state == c_ST_RUN) ? w_cmd_sel : '0;
        end
    end

    // --------------------------------------------------------------- outputs
    // The manual controller is held in reset everywhere except while it owns
    // the car, so every manual entry restarts it from scratch.
    assign w_run_manual = (r_state == c_ST_RUN) && (r_active_mode == MODE_MANUAL);

    always_comb begin
        manual_rst_n       = w_run_manual;
        manual_power_input = !w_run_manual;
        semi_en            = (r_state == c_ST_RUN) && (r_active_mode == MODE_SEMI);
        auto_en            = (r_state == c_ST_RUN) && (r_active_mode == MODE_AUTO);
        power_on           = (r_state == c_ST_WAIT_REL) || (r_state == c_ST_SWITCH) ||
                             (r_state == c_ST_RUN);
        drive_cmd          = r_drive_cmd;
        active_mode        = r_active_mode;
        fsm_state          = r_state;
    end

endmodule

`default_nettype wire

// File: tb/tb_drive_mode_arbiter.sv
// ============================================================================
//  Module   : tb_drive_mode_arbiter
//  Purpose  : Directed self-checking bench for drive_mode_arbiter with
//             LONG_PRESS_CYC=8 and SWITCH_GAP=2.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_drive_mode_arbiter;

    localparam int c_LP  = 8;
    localparam int c_GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       power_btn = 1'b0;
    logic [1:0] mode_sel = 2'b00;
    logic [3:0] manual_answer = 4'b0000;
    logic       manual_power_now = 1'b0;
    logic [3:0] semi_answer = 4'b0000;
    logic [3:0] auto_answer = 4'b0000;
    logic       manual_rst_n;
    logic       manual_power_input;
    logic       semi_en;
    logic       auto_en;
    logic [3:0] drive_cmd;
    logic       power_on;
    logic [1:0] active_mode;
    logic [2:0] fsm_state;

    // {power_on, manual_rst_n, manual_power_input, semi_en, auto_en}
    logic [4:0] flags;
    assign flags = {power_on, manual_rst_n, manual_power_input, semi_en, auto_en};

    int errors = 0;
    int checks = 0;

    drive_mode_arbiter #(
        .LONG_PRESS_CYC (c_LP),
        .SWITCH_GAP     (c_GAP)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .power_btn          (power_btn),
        .mode_sel           (mode_sel),
        .manual_answer      (manual_answer),
        .manual_power_now   (manual_power_now),
        .semi_answer        (semi_answer),
        .auto_answer        (auto_answer),
        .manual_rst_n       (manual_rst_n),
        .manual_power_input (manual_power_input),
        .semi_en            (semi_en),
        .auto_en            (auto_en),
        .drive_cmd          (drive_cmd),
        .power_on           (power_on),
        .active_mode        (active_mode),
        .fsm_state          (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full power-up into RUN: 1 cycle OFF->ARM, 8 ARM cycles, release,
    // 1 cycle WAIT_REL->SWITCH, 2 SWITCH cycles.
    task automatic power_up(input logic [1:0] m);
        mode_sel  = m;
        power_btn = 1'b1;
        tick(c_LP + 1);
        power_btn = 1'b0;
        tick(c_GAP + 1);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick(2);
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", fsm_state); end
        checks++; if (flags !== 5'b00100) begin errors++; $display("FAIL reset_flags got=%b exp=00100", flags); end
        checks++; if (drive_cmd !== 4'b0000) begin errors++; $display("FAIL reset_drive got=%b exp=0000", drive_cmd); end
        checks++; if (active_mode !== 2'b00) begin errors++; $display("FAIL reset_mode got=%b exp=00", active_mode); end
        rst = 1'b1;
        tick(1);
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL idle_state got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_short_press;
        power_btn = 1'b1;
        tick(5);
        checks++; if (fsm_state !== 3'd1) begin errors++; $display("FAIL short_arm got=%0d exp=1", fsm_state); end
        checks++; if (flags !== 5'b00100) begin errors++; $display("FAIL short_flags got=%b exp=00100", flags); end
        power_btn = 1'b0;
        tick(1);
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL short_off got=%0d exp=0", fsm_state); end
        checks++; if (power_on !== 1'b0) begin errors++; $display("FAIL short_power got=%b exp=0", power_on); end
    endtask

    task automatic test_semi_power_up;
        mode_sel    = 2'b01;
        semi_answer = 4'b0001;
        power_btn   = 1'b1;
        tick(c_LP);
        checks++; if (fsm_state !== 3'd1 || power_on !== 1'b0) begin errors++; $display("FAIL semi_not_yet got=%0d/%b exp=1/0", fsm_state, power_on); end
        tick(1);
        checks++; if (fsm_state !== 3'd2) begin errors++; $display("FAIL semi_wait_rel got=%0d exp=2", fsm_state); end
        checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL semi_wait_flags got=%b exp=10100", flags); end
        tick(1);
        checks++; if (fsm_state !== 3'd2) begin errors++; $display("FAIL semi_held got=%0d exp=2", fsm_state); end
        power_btn = 1'b0;
        tick(1);
        checks++; if (fsm_state !== 3'd3 || drive_cmd !== 4'b0000) begin errors++; $display("FAIL semi_gap1 got=%0d/%b exp=3/0000", fsm_state, drive_cmd); end
        checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL semi_gap_flags got=%b exp=10100", flags); end
        tick(1);
        checks++; if (fsm_state !== 3'd3 || drive_cmd !== 4'b0000) begin errors++; $display("FAIL semi_gap2 got=%0d/%b exp=3/0000", fsm_state, drive_cmd); end
        tick(1);
        checks++; if (fsm_state !== 3'd4) begin errors++; $display("FAIL semi_run got=%0d exp=4", fsm_state); end
        checks++; if (flags !== 5'b10110) begin errors++; $display("FAIL semi_run_flags got=%b exp=10110", flags); end
        checks++; if (active_mode !== 2'b01) begin errors++; $display("FAIL semi_mode got=%b exp=01", active_mode); end
        checks++; if (drive_cmd !== 4'b0001) begin errors++; $display("FAIL semi_cmd got=%b exp=0001", drive_cmd); end
        semi_answer = 4'b0110;
        #1;
        checks++; if (drive_cmd !== 4'b0001) begin errors++; $display("FAIL semi_lag got=%b exp=0001", drive_cmd); end
        tick(1);
        checks++; if (drive_cmd !== 4'b0110) begin errors++; $display("FAIL semi_follow got=%b exp=0110", drive_cmd); end
    endtask

    task automatic test_async_reset_run;
        #2 rst = 1'b0;
        #1;
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL async_state got=%0d exp=0", fsm_state); end
        checks++; if (flags !== 5'b00100) begin errors++; $display("FAIL async_flags got=%b exp=00100", flags); end
        checks++; if (drive_cmd !== 4'b0000 || active_mode !== 2'b00) begin errors++; $display("FAIL async_cmd_mode got=%b/%b exp=0000/00", drive_cmd, active_mode); end
        #2 rst = 1'b1;
        tick(1);
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL async_after got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_manual_to_auto;
        manual_answer = 4'b0000;
        power_up(2'b00);
        manual_answer = 4'b1010;
        tick(1);
        checks++; if (fsm_state !== 3'd4 || active_mode !== 2'b00) begin errors++; $display("FAIL man_run got=%0d/%b exp=4/00", fsm_state, active_mode); end
        checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL man_flags got=%b exp=11000", flags); end
        checks++; if (drive_cmd !== 4'b1010) begin errors++; $display("FAIL man_cmd got=%b exp=1010", drive_cmd); end
        mode_sel    = 2'b10;
        auto_answer = 4'b0101;
        tick(1);
        checks++; if (fsm_state !== 3'd3 || drive_cmd !== 4'b0000) begin errors++; $display("FAIL m2a_gap1 got=%0d/%b exp=3/0000", fsm_state, drive_cmd); end
        checks++; if (flags !== 5'b10100) begin errors++; $display("FAIL m2a_gap_flags got=%b exp=10100", flags); end
        tick(1);
        checks++; if (fsm_state !== 3'd3 || drive_cmd !== 4'b0000) begin errors++; $display("FAIL m2a_gap2 got=%0d/%b exp=3/0000", fsm_state, drive_cmd); end
        tick(1);
        checks++; if (fsm_state !== 3'd4 || active_mode !== 2'b10) begin errors++; $display("FAIL m2a_run got=%0d/%b exp=4/10", fsm_state, active_mode); end
        checks++; if (flags !== 5'b10101) begin errors++; $display("FAIL m2a_flags got=%b exp=10101", flags); end
        checks++; if (drive_cmd !== 4'b0101) begin errors++; $display("FAIL m2a_cmd got=%b exp=0101", drive_cmd); end
    endtask

    task automatic test_ignore_invalid;
        mode_sel         = 2'b11;
        manual_power_now = 1'b1;
        tick(2);
        checks++; if (fsm_state !== 3'd4 || active_mode !== 2'b10) begin errors++; $display("FAIL inv_hold got=%0d/%b exp=4/10", fsm_state, active_mode); end
        checks++; if (flags !== 5'b10101) begin errors++; $display("FAIL inv_flags got=%b exp=10101", flags); end
        manual_power_now = 1'b0;
        mode_sel         = 2'b10;
        tick(1);
    endtask

    task automatic test_btn_priority;
        mode_sel  = 2'b00;
        power_btn = 1'b1;
        tick(1);
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL prio_off got=%0d exp=0", fsm_state); end
        checks++; if (flags !== 5'b00100 || drive_cmd !== 4'b0000) begin errors++; $display("FAIL prio_outs got=%b/%b exp=00100/0000", flags, drive_cmd); end
        power_btn = 1'b0;
        tick(1);
        checks++; if (fsm_state !== 3'd0) begin errors++; $display("FAIL prio_stay got=%0d exp=0", fsm_state); end
    endtask

    task automatic test_manual_power_now;
        power_up(2'b00);
        manual_answer = 4'b1111;
        tick(1);
        checks++; if (drive_cmd !== 4'b1111) begin errors++; $display("FAIL mpn_cmd got=%b exp=1111", drive_cmd); end
        manual_power_now = 1'b1;
        tick(1);
        manual_power_now = 1'b0;
        checks++; if (fsm_state !== 3'd0 || drive_cmd !== 4'b0000) begin errors++; $display("FAIL mpn_off got=%0d/%b exp=0/0000", fsm_state, drive_cmd); end
        checks++; if (manual_power_input !== 1'b1 || flags !== 5'b00100) begin errors++; $display("FAIL mpn_flags got=%b exp=00100", flags); end
    endtask

    task automatic test_mode_over_power_now;
        power_up(2'b11);
        checks++; if (fsm_state !== 3'd4 || active_mode !== 2'b00) begin errors++; $display("FAIL inv_boot got=%0d/%b exp=4/00", fsm_state, active_mode); end
        checks++; if (flags !== 5'b11000) begin errors++; $display("FAIL inv_boot_flags got=%b exp=11000", flags); end
        mode_sel         = 2'b01;
        manual_power_now = 1'b1;
        tick(1);
        manual_power_now = 1'b0;
        checks++; if (fsm_state !== 3'd3) begin errors++; $display("FAIL mode_over_mpn got=%0d exp=3", fsm_state); end
        power_btn = 1'b1;
        tick(1);
        checks++; if (fsm_state !== 3'd0 || power_on !== 1'b0) begin errors++; $display("FAIL switch_abort got=%0d/%b exp=0/0", fsm_state, power_on); end
        power_btn = 1'b0;
        tick(1);
    endtask

    task automatic test_reset_mid_arm;
        power_btn = 1'b1;
        tick(7);
        checks++; if (fsm_state !== 3'd1) begin errors++; $display("FAIL arm6_state got=%0d exp=1", fsm_state); end
        #2 rst = 1'b0;
        #1;
        checks++; if (fsm_state !== 3'd0 || flags !== 5'b00100) begin errors++; $display("FAIL arm6_reset got=%0d/%b exp=0/00100", fsm_state, flags); end
        #2 rst = 1'b1;
        power_btn = 1'b0;
        tick(1);
        power_btn = 1'b1;
        tick(7);
        checks++; if (fsm_state !== 3'd1 || power_on !== 1'b0) begin errors++; $display("FAIL press7_arm got=%0d/%b exp=1/0", fsm_state, power_on); end
        power_btn = 1'b0;
        tick(1);
        checks++; if (fsm_state !== 3'd0 || flags !== 5'b00100) begin errors++; $display("FAIL press7_off got=%0d/%b exp=0/00100", fsm_state, flags); end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_semi_power_up();
        test_async_reset_run();
        test_manual_to_auto();
        test_ignore_invalid();
        test_btn_priority();
        test_manual_power_now();
        test_mode_over_power_now();
        test_reset_mid_arm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
